fp16_add_arbiter: RTL and testbench
===================================

# fp16_add_arbiter

Round-robin arbiter and sequencer that shares one registered `fp16adder` instance between `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the granted pair onto the adder inputs. It tracks each in-flight operation's requester ID through a tag pipeline matched to the adder latency, and returns each result to its originating requester on a one-hot response bus.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `ADD_LATENCY`, 1: cycles from `add_a`/`add_b` valid to `add_x` valid (the registered adder is 1).
- `IDW`, `$clog2(NREQ)`: requester ID width.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester operand pair valid.
- `req_ready`  out  NREQ: one-hot grant; at most one bit high.
- `req_a`  in  16*NREQ: operand A, requester i at bits [16i+15:16i].
- `req_b`  in  16*NREQ: operand B, same packing.
- `add_rst_n`  out  1: active-low reset to the adder, equal to `~rst`.
- `add_a`  out  16: registered operand A to the adder.
- `add_b`  out  16: registered operand B to the adder.
- `add_x`  in  16: adder result.
- `rsp_valid`  out  NREQ: one-hot, one-cycle result strobe. No backpressure; requesters must accept.
- `rsp_data`  out  16: result, valid when any `rsp_valid` bit is set.
- `rsp_id`  out  IDW: index of the requester being answered.
- `busy`  out  1: high while any operation is in flight (issue stage, tag pipe, or response stage).

## Operation
- Round-robin pointer `ptr` (IDW bits) resets to 0.
- Grant logic (combinational):
  - The grant goes to the first i with `req_valid[i]`, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[i]` is 1 only for that i; all zeros if there are no requests.
  - `ready` never depends on `valid` of other cycles and never asserts without `valid`.
- A handshake is `req_valid[i] & req_ready[i]` at a rising edge. On a handshake from requester g:
  - `ptr <= (g+1) mod NREQ`. With no handshake, `ptr` holds.
  - `add_a <= req_a[g]`, `add_b <= req_b[g]`.
  - The issue stage captures `{1, g}`.
- With no handshake, `add_a`/`add_b` hold their values and the issue stage captures `{0, x}`.
- Tag pipe:
  - `ADD_LATENCY`-deep shift register of `{vld, id}`, fed from the issue stage.
  - Its output aligns with `add_x`.
- Response stage (registered):
  - When the tag pipe output `vld` is 1: `rsp_valid <= onehot(id)`, `rsp_id <= id`, `rsp_data <= add_x`.
  - Otherwise `rsp_valid <= 0`. `rsp_data` and `rsp_id` hold.
- Throughput: one accepted operation per cycle, sustained. No internal FIFO is needed because the adder is fully pipelined.
- Arithmetic is the adder's: same-sign addition only. The sign is taken from A. The arbiter does not inspect operands.

## Timing
- Handshake at the edge ending cycle T:
  - `add_a`/`add_b` are valid in cycle T+1.
  - `add_x` is valid in cycle T+1+ADD_LATENCY.
  - `rsp_valid`/`rsp_data` are valid in cycle T+2+ADD_LATENCY (3 cycles with the default).
- Responses come out in acceptance order. Two back-to-back accepts produce two back-to-back responses.
- Reset, while `rst` is high at an edge:
  - Cleared to 0: `ptr`, `add_a`, `add_b`, issue stage, all tag pipe `vld` bits, `rsp_valid`, `rsp_data`, `rsp_id`.
  - `req_ready` is forced to 0 and `busy` is 0. `add_rst_n` is 0, which clears the adder.
- Reset mid-operation: all in-flight operations are dropped and no response is ever produced for them. The first accept is possible in the first cycle after `rst` falls.
- If all NREQ requesters are valid every cycle, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 cycles.
- If a requester deasserts `valid` without a handshake, nothing is recorded and `ptr` is unchanged.
- A new handshake in the same cycle as a response to the same requester is legal. Both take effect independently.
- `busy` = issue `vld` | any tag `vld` | any `rsp_valid`.

## Test plan
- Reset, then requester 0 sends A=0x3C00, B=0x3C00 (1.0+1.0) → exactly one `req_ready` pulse. `rsp_valid`=0001, `rsp_id`=0, `rsp_data`=0x4000 exactly 3 cycles after the handshake. `busy` falls the cycle after.
- All 4 requesters valid continuously for 8 cycles with distinct operands → grants 0,1,2,3,0,1,2,3. Responses are back-to-back in the same order, each `rsp_data` matching the adder model for that pair.
- `ptr`=2 after a grant to 1, then only requesters 0 and 3 valid → grant 3, then 0. Wrap-around is verified.
- Requester 1 sends 0x4000+0x4000 and requester 2 sends 0x3E00+0x3E00 on consecutive cycles → responses are 0x4400 to id 1, then 0x4200 to id 2, in consecutive cycles.
- Assert `rst` for 1 cycle, one cycle after two accepts → no `rsp_valid` ever appears for them. All outputs are 0 during reset. A fresh request right after reset completes normally in 3 cycles.
- `req_valid` is all zeros for 10 cycles → `req_ready` stays 0, `rsp_valid` stays 0, `busy` stays 0, and `add_a`/`add_b` are unchanged.

Source files
------------

// File: rtl/fp16_add_arbiter.sv
// Round-robin front end sharing one pipelined fp16 adder between NREQ requesters.
// Operands are registered onto the adder; a tag pipe routes each result back to its requester.
module fp16_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 1,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 add_rst_n,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [15:0]          add_x,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

  logic [IDW-1:0]                  ptr_r;
  logic [15:0]                     add_a_r;
  logic [15:0]                     add_b_r;
  logic                            iss_vld_r;
  logic [IDW-1:0]                  iss_id_r;
  logic [ADD_LATENCY-1:0]          tag_vld_r;
  logic [ADD_LATENCY-1:0][IDW-1:0] tag_id_r;
  logic [NREQ-1:0]                 rsp_valid_r;
  logic [15:0]                     rsp_data_r;
  logic [IDW-1:0]                  rsp_id_r;

  logic           grant_found_s;
  logic [IDW-1:0] grant_id_s;
  logic [IDW:0]   cand_s;
  logic           hit_s;
  logic           hs_s;
  logic [15:0]    sel_a_s;
  logic [15:0]    sel_b_s;

  // Search upward from ptr (with wrap) for the first valid requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s        = {1'b0, ptr_r} + (IDW+1)'(k);
      cand_s        = (cand_s >= (IDW+1)'(NREQ)) ? cand_s - (IDW+1)'(NREQ) : cand_s;
      hit_s         = ~grant_found_s & req_valid[cand_s[IDW-1:0]];
      grant_id_s    = hit_s ? cand_s[IDW-1:0] : grant_id_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s = 16'h0000;
    sel_b_s = 16'h0000;
    for (int k = 0; k < NREQ; k++) begin
      sel_a_s = sel_a_s | ((grant_id_s == IDW'(k)) ? req_a[16*k +: 16] : 16'h0000);
      sel_b_s = sel_b_s | ((grant_id_s == IDW'(k)) ? req_b[16*k +: 16] : 16'h0000);
    end
  end

  assign hs_s      = grant_found_s & ~rst;
  assign req_ready = hs_s ? onehot(grant_id_s) : {NREQ{1'b0}};

  // Issue stage, tag pipe and response stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= '0;
      add_a_r     <= 16'h0000;
      add_b_r     <= 16'h0000;
      iss_vld_r   <= 1'b0;
      iss_id_r    <= '0;
      tag_vld_r   <= '0;
      tag_id_r    <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= 16'h0000;
      rsp_id_r    <= '0;
    end else begin
      if (hs_s) begin
        ptr_r   <= (grant_id_s == IDW'(NREQ-1)) ? '0 : grant_id_s + IDW'(1);
        add_a_r <= sel_a_s;
        add_b_r <= sel_b_s;
      end
      iss_vld_r   <= hs_s;
      iss_id_r    <= grant_id_s;
      tag_vld_r[0] <= iss_vld_r;
      tag_id_r[0]  <= iss_id_r;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
      // The last tag stage lines up with add_x.
      if (tag_vld_r[ADD_LATENCY-1]) begin
        rsp_valid_r <= onehot(tag_id_r[ADD_LATENCY-1]);
        rsp_id_r    <= tag_id_r[ADD_LATENCY-1];
        rsp_data_r  <= add_x;
      end else begin
        rsp_valid_r <= '0;
      end
    end
  end

  assign add_rst_n = ~rst;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = ~rst & (iss_vld_r | (|tag_vld_r) | (|rsp_valid_r));

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: a behavioural registered fp16 adder sits on the adder port,
// a forked monitor models the round-robin grant and scoreboards every response.
module tb_fp16_add_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        add_rst_n;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_x;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mptr  = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  fp16_add_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_rst_n(add_rst_n), .add_a(add_a),
    .add_b(add_b), .add_x(add_x), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Same-sign fp16 add, sign from A, truncating alignment.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  ea, eb, e;
    logic [11:0] ma, mb, s;
    ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma = {1'b0, (a[14:10] != 5'd0), a[9:0]};
    mb = {1'b0, (b[14:10] != 5'd0), b[9:0]};
    if (eb > ea) begin
      ma = ma >> (eb - ea);
      e  = eb;
    end else begin
      mb = mb >> (ea - eb);
      e  = ea;
    end
    s = ma + mb;
    if (s[11]) begin
      s = s >> 1;
      e = e + 5'd1;
    end
    if (e == 5'd31) return {a[15], 5'd31, 10'd0};
    if (!s[10]) e = 5'd0;
    return {a[15], e, s[9:0]};
  endfunction

  // Registered adder model (latency 1), cleared by add_rst_n.
  always @(posedge clk) begin
    if (!add_rst_n) add_x <= 16'h0000;
    else            add_x <= fp16_add(add_a, add_b);
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic monitor();
    int          g;
    int          idx;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_v;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mptr = 0;
        sb.delete();
        tests++;
        if (req_ready !== 4'b0000) begin
          fails++;
          $display("FAIL ready_in_reset: got %b want 0000", req_ready);
        end
      end else begin
        if (rsp_valid !== 4'b0000) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rsp: got rsp_valid=%b id=%0d data=%h want none", rsp_valid, rsp_id, rsp_data);
          end else begin
            e = sb.pop_front();
            exp_v = 4'b0001 << e.id;
            if (rsp_valid !== exp_v || rsp_id !== 2'(e.id) || rsp_data !== e.data || cyc != e.cyc + 3) begin
              fails++;
              $display("FAIL rsp: got v=%b id=%0d data=%h cyc=%0d want v=%b id=%0d data=%h cyc=%0d",
                       rsp_valid, rsp_id, rsp_data, cyc, exp_v, e.id, e.data, e.cyc + 3);
            end
          end
        end else if (sb.size() > 0 && sb[0].cyc + 3 <= cyc) begin
          tests++;
          fails++;
          e = sb.pop_front();
          $display("FAIL missing_rsp: got none at cyc %0d want id=%0d data=%h", cyc, e.id, e.data);
        end
        g = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (mptr + k) % 4;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
        tests++;
        if (req_ready !== exp_rdy) begin
          fails++;
          $display("FAIL grant: got %b want %b (cyc %0d)", req_ready, exp_rdy, cyc);
        end
        if (g >= 0) begin
          sb.push_back('{g, fp16_add(req_a[16*g +: 16], req_b[16*g +: 16]), cyc});
          mptr = (g + 1) % 4;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(2);
    tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || rsp_id !== 2'd0 ||
        add_a !== 16'h0000 || add_b !== 16'h0000 || busy !== 1'b0 || add_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h id=%0d a=%h b=%h busy=%b arn=%b want all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, add_a, add_b, busy, add_rst_n);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp_busy;
    set_op(0, 16'h3C00, 16'h3C00);
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    cycle(1);
    req_valid = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      exp_busy = (k <= 3);
      tests++;
      if (rsp_valid !== ((k == 3) ? 4'b0001 : 4'b0000) || busy !== exp_busy) begin
        fails++;
        $display("FAIL single_timing: k=%0d got v=%b busy=%b want v=%b busy=%b",
                 k, rsp_valid, busy, (k == 3) ? 4'b0001 : 4'b0000, exp_busy);
      end
      if (k >= 3) begin
        tests++;
        if (rsp_data !== 16'h4000 || rsp_id !== 2'd0) begin
          fails++;
          $display("FAIL single_data: k=%0d got %h id %0d want 4000 id 0", k, rsp_data, rsp_id);
        end
      end
      cycle(1);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_rdy;
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++)
        set_op(i, {1'b0, 5'd15, 10'(c * 40 + i * 7)}, {1'b0, 5'd14, 10'(c * 13 + i * 50)});
      req_valid = 4'b1111;
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      tests++;
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL rotate_grant: c=%0d got %b want %b", c, req_ready, exp_rdy);
      end
      cycle(1);
    end
    req_valid = 4'b0000;
    cycle(6);
  endtask

  task automatic test_wrap();
    set_op(1, 16'h3C00, 16'h3800);
    set_op(0, 16'h4000, 16'h3C00);
    set_op(3, 16'h4400, 16'h4000);
    req_valid = 4'b0010;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL wrap_g1: got %b want 0010", req_ready);
    end
    cycle(1);
    req_valid = 4'b1001;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_g3: got %b want 1000", req_ready);
    end
    cycle(1);
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_g0: got %b want 0001", req_ready);
    end
    cycle(1);
    req_valid = 4'b0000;
    cycle(5);
  endtask

  task automatic test_back_to_back();
    set_op(1, 16'h4000, 16'h4000);
    req_valid = 4'b0010;
    cycle(1);
    set_op(2, 16'h3E00, 16'h3E00);
    req_valid = 4'b0100;
    cycle(1);
    req_valid = 4'b0000;
    cycle(1);
    tests++;
    if (rsp_valid !== 4'b0010 || rsp_id !== 2'd1 || rsp_data !== 16'h4400) begin
      fails++;
      $display("FAIL b2b_first: got v=%b id=%0d d=%h want 0010 1 4400", rsp_valid, rsp_id, rsp_data);
    end
    cycle(1);
    tests++;
    if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_data !== 16'h4200) begin
      fails++;
      $display("FAIL b2b_second: got v=%b id=%0d d=%h want 0100 2 4200", rsp_valid, rsp_id, rsp_data);
    end
    cycle(3);
  endtask

  task automatic test_reset_mid();
    set_op(0, 16'h3C00, 16'h3C00);
    req_valid = 4'b0001;
    cycle(1);
    set_op(1, 16'h4000, 16'h4000);
    req_valid = 4'b0010;
    cycle(1);
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0000 || busy !== 1'b0 || add_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL midrst_comb: got rdy=%b busy=%b arn=%b want 0000 0 0", req_ready, busy, add_rst_n);
    end
    cycle(1);
    rst = 1'b0;
    tests++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || rsp_id !== 2'd0 ||
        add_a !== 16'h0000 || add_b !== 16'h0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_regs: got v=%b d=%h id=%0d a=%h b=%h busy=%b want all 0",
               rsp_valid, rsp_data, rsp_id, add_a, add_b, busy);
    end
    set_op(2, 16'h3C00, 16'h3C00);
    req_valid = 4'b0100;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL midrst_fresh_ready: got %b want 0100", req_ready);
    end
    cycle(1);
    req_valid = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (rsp_valid !== ((k == 3) ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("FAIL midrst_rsp: k=%0d got %b want %b", k, rsp_valid, (k == 3) ? 4'b0100 : 4'b0000);
      end
      if (k == 3) begin
        tests++;
        if (rsp_data !== 16'h4000 || rsp_id !== 2'd2) begin
          fails++;
          $display("FAIL midrst_data: got %h id %0d want 4000 id 2", rsp_data, rsp_id);
        end
      end
      cycle(1);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0 ||
          add_a !== 16'h3C00 || add_b !== 16'h3C00) begin
        fails++;
        $display("FAIL idle: k=%0d got rdy=%b v=%b busy=%b a=%h b=%h want 0000 0000 0 3c00 3c00",
                 k, req_ready, rsp_valid, busy, add_a, add_b);
      end
      cycle(1);
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = 64'd0;
    req_b     = 64'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_rotate();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    cycle(4);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d outstanding want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
